// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: operand-forward selects and
// divider sequencer states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/hazard_ctrl_div_sequencer.sv
// Tracks one iterative divide from start pulse to completion so the pipeline can hold
// the divide in Execute; DONE lasts one cycle so a still-high divE cannot restart it.
module div_sequencer
    import hazard_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic div_e_i,
    input  logic div_done_i,
    output logic div_start_o,
    output logic divstall_o
);

    div_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (div_e_i) state_d = StBusy;
            StBusy:  if (div_done_i) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Gated by reset so a high divE during reset cannot leak a start or stall.
    assign div_start_o = rst_ni && (state_q == StIdle) && div_e_i;
    assign divstall_o  = rst_ni && (((state_q == StIdle) && div_e_i) || (state_q == StBusy));

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use and branch stalls, and
// holding of Execute while the iterative divider runs.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             divE,
    input  logic             div_done,
    output logic             div_start,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushE,
    output logic             flushM
);

    logic m_wr_valid, w_wr_valid, e_wr_valid, e_load_valid, m_load_valid;
    logic lwstall, brstall, divstall;

    // Register zero is hard-wired, so a write to it never creates a dependency.
    assign m_wr_valid   = regwriteM && (writeregM != '0);
    assign w_wr_valid   = regwriteW && (writeregW != '0);
    assign e_wr_valid   = regwriteE && (writeregE != '0);
    assign e_load_valid = memtoregE && e_wr_valid;
    assign m_load_valid = memtoregM && (writeregM != '0);

    always_comb begin
        forwardAE = FWD_RF;
        if (m_wr_valid && (writeregM == rsE)) begin
            forwardAE = FWD_M;
        end else if (w_wr_valid && (writeregW == rsE)) begin
            forwardAE = FWD_W;
        end
        forwardBE = FWD_RF;
        if (m_wr_valid && (writeregM == rtE)) begin
            forwardBE = FWD_M;
        end else if (w_wr_valid && (writeregW == rtE)) begin
            forwardBE = FWD_W;
        end
    end

    assign forwardAD = m_wr_valid && (writeregM == rsD);
    assign forwardBD = m_wr_valid && (writeregM == rtD);

    always_comb begin
        lwstall = resetn && e_load_valid && ((writeregE == rsD) || (writeregE == rtD));
        brstall = resetn && branchD &&
                  ((e_wr_valid && ((writeregE == rsD) || (writeregE == rtD))) ||
                   (m_load_valid && ((writeregM == rsD) || (writeregM == rtD))));
    end

    div_sequencer u_div_sequencer (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .div_e_i     (divE),
        .div_done_i  (div_done),
        .div_start_o (div_start),
        .divstall_o  (divstall)
    );

    assign stallF = lwstall || brstall || divstall;
    assign stallD = stallF;
    // E holds the divide while a bubble drains into M; flushing E would lose the divide.
    assign stallE = divstall;
    assign flushM = divstall;
    assign flushE = (lwstall || brstall) && !divstall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: literal checks on key scenarios plus a per-cycle
// comparison against a rule-level model of forwarding, stalls and divide occupancy.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, divE, div_done;
    logic       div_start, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, flushE, flushM;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    hazard_ctrl #(.REG_W(5)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rsD       (rsD),
        .rtD       (rtD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeregE (writeregE),
        .writeregM (writeregM),
        .writeregW (writeregW),
        .regwriteE (regwriteE),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .memtoregE (memtoregE),
        .memtoregM (memtoregM),
        .branchD   (branchD),
        .divE      (divE),
        .div_done  (div_done),
        .div_start (div_start),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .flushE    (flushE),
        .flushM    (flushM)
    );

    always #5 clk = ~clk;

    // Model: a divide is "in flight" from the cycle after its start until div_done,
    // followed by one grace cycle in which no new divide may begin.
    bit m_inflight, m_grace;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_inflight <= 1'b0;
            m_grace    <= 1'b0;
        end else if (m_grace) begin
            m_grace <= 1'b0;
        end else if (m_inflight) begin
            if (div_done) begin
                m_inflight <= 1'b0;
                m_grace    <= 1'b1;
            end
        end else if (divE) begin
            m_inflight <= 1'b1;
        end
    end

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (regwriteM && writeregM != 0 && writeregM == src) return 2'd2;
        if (regwriteW && writeregW != 0 && writeregW == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [13:0] model_out();
        logic lw, br, dv, st, fad, fbd;
        fad = regwriteM && writeregM != 0 && writeregM == rsD;
        fbd = regwriteM && writeregM != 0 && writeregM == rtD;
        lw  = resetn && memtoregE && regwriteE && writeregE != 0 &&
              (writeregE == rsD || writeregE == rtD);
        br  = resetn && branchD &&
              ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
               (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
        st  = resetn && !m_inflight && !m_grace && divE;
        dv  = st || (resetn && m_inflight);
        return {model_fwd(rsE), model_fwd(rtE), fad, fbd, st,
                lw || br || dv, lw || br || dv, dv, (lw || br) && !dv, dv};
    endfunction

    always @(negedge clk) begin
        logic [13:0] exp_v, act_v;
        if (cmp_en) begin
            exp_v = model_out();
            act_v = {forwardAE, forwardBE, forwardAD, forwardBD, div_start,
                     stallF, stallD, stallE, flushE, flushM};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual=%b required=%b", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; divE = 0; div_done = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt, start_cnt;
        clear_inputs();
        resetn = 1'b0;
        // Reset: stalls forced low even with stall-causing inputs; forwards still live.
        divE = 1; branchD = 1; regwriteE = 1; memtoregE = 1; writeregE = 3; rsD = 3;
        regwriteM = 1; writeregM = 8; rsE = 8;
        #3;
        check("reset_stallF", stallF, 0);
        check("reset_flushE", flushE, 0);
        check("reset_div_start", div_start, 0);
        check("reset_stallE", stallE, 0);
        check("reset_forwardAE", forwardAE, 2'b10);
        clear_inputs();
        @(posedge clk);
        #2 resetn = 1'b1;
        cmp_en = 1'b1;
        step();

        // M-over-W priority.
        rsE = 8; regwriteM = 1; writeregM = 8; regwriteW = 1; writeregW = 8;
        #1 check("prio_fwdAE_M", forwardAE, 2'b10);
        writeregM = 0;
        #1 check("prio_fwdAE_W", forwardAE, 2'b01);
        rtE = 8;
        #1 check("fwdBE_W", forwardBE, 2'b01);
        writeregM = 8; rsD = 8; rtD = 9;
        #1 check("fwdAD", forwardAD, 1);
        check("fwdBD", forwardBD, 0);
        step();

        // Load-use.
        clear_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 5; rtD = 5;
        #1 check("lu_stallF", stallF, 1);
        check("lu_stallD", stallD, 1);
        check("lu_flushE", flushE, 1);
        check("lu_stallE", stallE, 0);
        step();
        clear_inputs();
        #1 check("lu_released", stallF, 0);
        step();

        // Branch stalls from an E-stage ALU result and an M-stage load.
        branchD = 1; regwriteE = 1; writeregE = 3; rsD = 3;
        #1 check("br_e_flushE", flushE, 1);
        regwriteE = 0; memtoregM = 1; writeregM = 4; rsD = 0; rtD = 4;
        #1 check("br_m_stallD", stallD, 1);
        step();

        // Register zero.
        clear_inputs();
        regwriteM = 1; writeregM = 0; rsE = 0;
        #1 check("r0_fwdAE", forwardAE, 2'b00);
        memtoregE = 1; regwriteE = 1; writeregE = 0; rsD = 0;
        #1 check("r0_no_lwstall", stallF, 0);
        step();

        // Divide: start, 32 busy cycles, done on the 32nd, then one DONE cycle.
        clear_inputs();
        divE = 1;
        stall_cnt = 0; start_cnt = 0;
        for (int c = 0; c < 34; c++) begin
            div_done = (c == 32);
            #1;
            if (stallF && stallD && stallE && flushM) stall_cnt++;
            if (div_start) start_cnt++;
            if (c == 33) begin
                check("div_done_no_stall", stallE, 0);
                check("div_done_no_start", div_start, 0);
            end
            step();
        end
        check("div_stall_cycles", (stall_cnt == 33) ? 2'd1 : 2'd0, 2'd1);
        check("div_start_count", (start_cnt == 1) ? 2'd1 : 2'd0, 2'd1);
        clear_inputs();
        step();

        // Reset during BUSY cycle 10.
        divE = 1;
        step();
        for (int i = 1; i < 10; i++) step();
        #1 check("busy10_stallE", stallE, 1);
        #1 resetn = 1'b0;
        #1 check("rst_mid_stallF", stallF, 0);
        check("rst_mid_stallE", stallE, 0);
        check("rst_mid_flushM", flushM, 0);
        check("rst_mid_div_start", div_start, 0);
        @(posedge clk);
        #2 resetn = 1'b1;
        start_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (div_start) start_cnt++;
            step();
        end
        check("rst_restart_count", (start_cnt == 1) ? 2'd1 : 2'd0, 2'd1);
        divE = 0; div_done = 1;
        step();
        div_done = 0;
        step();
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, giving the register-index width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports rsD, rtD, input, REG_W each: source registers of the Decode-stage instruction.
REQ-005 SHALL have ports rsE, rtE, writeregE, input, REG_W each: Execute-stage sources and destination.
REQ-006 SHALL have ports writeregM, writeregW, input, REG_W each: Memory- and Writeback-stage destinations.
REQ-007 SHALL have ports regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, input, 1 bit each: stage write-enable and load flags.
REQ-008 SHALL have port branchD, input, 1 bit: the Decode-stage instruction is a branch compared in Decode.
REQ-009 SHALL have port divE, input, 1 bit: the Execute-stage instruction is a divide.
REQ-010 SHALL have port div_done, input, 1 bit: one-cycle completion pulse from the iterative divider.
REQ-011 SHALL have port div_start, output, 1 bit: one-cycle start pulse to the divider.
REQ-012 SHALL have ports forwardAE, forwardBE, output, 2 bits each: select lines for the Execute-stage 3-input operand muxes.
REQ-013 SHALL have ports forwardAD, forwardBD, output, 1 bit each: Decode-stage branch-compare forwarding from M.
REQ-014 SHALL have ports stallF, stallD, stallE, flushE, flushM, output, 1 bit each: pipeline register controls.

Function
REQ-015 SHALL encode forwardXE as 00 for register file, 01 for resultW, 10 for aluoutM; SHALL never output 11.
REQ-016 SHALL drive forwardAE = 10 when regwriteM, writeregM != 0 and writeregM == rsE; else 01 when regwriteW, writeregW != 0 and writeregW == rsE; else 00. forwardBE follows the same rule using rtE; M has priority over W.
REQ-017 SHALL drive forwardAD = 1 when regwriteM, writeregM != 0 and writeregM == rsD; forwardBD follows the same rule using rtD.
REQ-018 SHALL assert lwstall when memtoregE and regwriteE are high, writeregE != 0, and writeregE equals rsD or rtD.
REQ-019 SHALL assert brstall when branchD is high and either (regwriteE and writeregE != 0 equals rsD or rtD) or (memtoregM and writeregM != 0 equals rsD or rtD).
REQ-020 SHALL implement divider FSM states IDLE, BUSY and DONE.
REQ-021 SHALL, in IDLE with divE high, pulse div_start for exactly that cycle and move to BUSY.
REQ-022 SHALL remain in BUSY until div_done, then move to DONE; SHALL leave DONE for IDLE unconditionally after one cycle.
REQ-023 SHALL NOT assert div_start in BUSY or DONE, even with divE high, so one divide is never restarted.
REQ-024 SHALL define divstall as (IDLE and divE) or BUSY; div_done arriving in the start cycle is ignored.
REQ-025 SHALL drive stallF = stallD = lwstall | brstall | divstall.
REQ-026 SHALL drive stallE = divstall and flushM = divstall, inserting a bubble into M while E holds.
REQ-027 SHALL drive flushE = (lwstall | brstall) & ~divstall, so the held divide in E is never flushed.
REQ-028 SHALL make all outputs combinational from state and inputs, with zero added latency.

Reset
REQ-029 SHALL force state to IDLE immediately when resetn is low, independent of clk.
REQ-030 SHALL hold div_start, all stalls and all flushes at 0 while resetn is low; forward outputs stay purely combinational.
REQ-031 SHALL, if resetn falls while in BUSY, abandon the divide; it SHALL NOT issue div_start again until divE is seen in IDLE after reset.

Structure
REQ-032 SHALL take the forward encodings FWD_RF, FWD_W, FWD_M and the FSM state encodings from shared package hazard_pkg.
REQ-033 SHALL place the IDLE/BUSY/DONE FSM in one sub-module, div_sequencer, with outputs div_start and divstall; forwarding and stall logic stay at the top level.

Verification
REQ-034 SHALL check M-over-W priority: rsE = 8, regwriteM = 1, writeregM = 8, regwriteW = 1, writeregW = 8 gives forwardAE = 10; with writeregM = 0 it gives 01.
REQ-035 SHALL check load-use: memtoregE = 1, regwriteE = 1, writeregE = 5, rtD = 5 gives stallF = stallD = flushE = 1 and stallE = 0 for one cycle.
REQ-036 SHALL check a divide: divE held high gives div_start for 1 cycle; div_done 32 cycles later keeps stallF/D/E and flushM high for 33 cycles, then DONE with no stall and no second div_start.
REQ-037 SHALL check register zero: writeregM = 0, regwriteM = 1, rsE = 0 gives forwardAE = 00, and writeregE = 0 gives no lwstall.
REQ-038 SHALL check reset mid-divide: resetn low at BUSY cycle 10 clears all stalls at once; after release with divE = 1, exactly one new div_start is issued.
